// File: rtl/ram_pkg.sv
// Shared types and defaults for the parametrised zero-initialised RAM.
// Imported by the sweeper and the ram_n top level.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RAM_WIDTH  = 16;
  localparam int RAM_ADDR_W = 6;

endpackage

// File: rtl/ram_init_sweeper.sv
// INIT/RUN controller: walks cnt over every address writing zeros,
// then hands the array to the user port until the next clear.
module ram_init_sweeper
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  output logic              ready_o,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_addr_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (clear_i) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (&cnt_q) state_d = RUN;
        end
      end
      RUN: begin
        if (clear_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_o      = (state_q == RUN);
  assign sweep_we_o   = (state_q == INIT);
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/ram_n.sv
// Single-port WIDTH x 2^ADDR_W RAM with hardware zero sweep after
// reset or clear, and an optional registered (write-first) read port.
module ram_n
  import ram_pkg::*;
#(
  parameter int WIDTH    = RAM_WIDTH,
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              user_we;

  logic [WIDTH-1:0] mem_q [DEPTH];

  ram_init_sweeper #(
    .ADDR_W(ADDR_W)
  ) u_sweep (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .ready_o     (ready),
    .sweep_we_o  (sweep_we),
    .sweep_addr_o(sweep_addr)
  );

  // clear beats load: a colliding write is dropped
  assign user_we = ready & load & ~clear;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (user_we) begin
      mem_q[address] <= in;
    end
  end

  generate
    if (READ_REG != 0) begin : g_reg
      logic [WIDTH-1:0] out_q, out_d;

      always_comb begin
        out_d = '0;
        if (ready && !clear) begin
          out_d = load ? in : mem_q[address];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
      end

      assign out = out_q;
    end else begin : g_comb
      assign out = ready ? mem_q[address] : '0;
    end
  endgenerate

endmodule

// File: doc/ram_n.md
# ram_n

Parametrised successor to the fixed-size RAM8/RAM64 family: a single-port WIDTH x 2^ADDR_W word memory with an optional registered read port. It adds a hardware zero-initialisation sweep after reset and on request, so memory contents are deterministic. It sits wherever the design needs RAM of arbitrary width or depth, such as data memory or screen buffers, and replaces hand-built RAM8/RAM64 stacks.

## Interface
- WIDTH, 16, word width in bits (>=1)
- ADDR_W, 6, address width; depth DEPTH = 2^ADDR_W (1..14)
- READ_REG, 0, 0 = combinational read (RAM64-compatible); 1 = one-cycle registered read
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  write enable; honoured only when ready=1
- address  input  ADDR_W  read/write address
- in  input  WIDTH  write data
- clear  input  1  when ready=1, starts a new zero-fill sweep; when ready=0, restarts the sweep
- out  output  WIDTH  read data
- ready  output  1  high when the memory is in the RUN state and accepts writes

## Operation
- **States:** INIT (sweep) and RUN.
- **Reset (rst_n=0, asynchronous):**
  - state=INIT, sweep counter cnt=0, ready=0.
  - Registered out=0.
  - Memory array is not reset directly; the sweep clears it.
- **INIT:**
  - Each edge writes 0 to mem[cnt] and increments cnt.
  - The edge that writes mem[DEPTH-1] moves the block to RUN; cnt wraps to 0.
  - load, address and in are ignored.
  - out reads 0 in both READ_REG modes.
  - clear=1 resets cnt to 0; the sweep restarts and takes a full DEPTH cycles again.
- **RUN:**
  - If load=1: mem[address] <= in on the edge.
  - If clear=1: go to INIT with cnt=0 on the edge; ready=0 from that edge.
  - If load and clear are both 1: clear wins and the write is dropped.
- **Read, READ_REG=0:**
  - out = mem[address] combinationally while ready=1.
  - A write becomes visible after the edge, as in RAM64.
- **Read, READ_REG=1:**
  - out <= mem[address] on each edge while in RUN.
  - Write-first: if load=1, out takes in on the same edge.
  - On the RUN->INIT edge, out <= 0.
- **Widths and addressing:**
  - address is full-width, so no out-of-range case exists.
  - cnt is ADDR_W bits; terminal count is all-ones.

## Timing
- After rst_n rises, ready=1 after exactly DEPTH rising edges; 64 for the defaults.
- clear pulse in RUN: ready is low for DEPTH edges. The first write is accepted on edge DEPTH+1 after the clear edge.
- Write-to-read latency:
  - READ_REG=0: 0 cycles after the write edge.
  - READ_REG=1: out shows the written value on the write edge itself (write-first).
- Read latency:
  - READ_REG=0: combinational.
  - READ_REG=1: 1 cycle from address to out.
- rst_n asserted mid-sweep or mid-RUN aborts immediately. A full sweep restarts on release.

## Structure
- Package ram_pkg:
  - state encoding (INIT=1'b0, RUN=1'b1)
  - default constants RAM_WIDTH=16 and RAM_ADDR_W=6
- Sub-module ram_init_sweeper:
  - contains the FSM and the cnt counter
  - outputs ready, sweep_we and sweep_addr
- Top level:
  - muxes sweep writes against user writes into the storage array
  - holds the optional output register, built with a generate on READ_REG

## Test plan
- **Reset/sweep:** preload garbage through a backdoor, release rst_n, count edges -> ready rises after exactly 64 edges and every address reads 0x0000.
- **Write/read, READ_REG=0:** load=1, addr=5, in=0xBEEF, then load=0 -> out=0xBEEF on the cycle after the edge. addr=6 -> out=0x0000.
- **Registered write-first, READ_REG=1:** load=1, addr=63, in=0x1234 -> out=0x1234 at that edge. Next cycle addr=0 -> out=0x0000 one edge later.
- **Clear and collision:** in RUN, drive load=1, clear=1 with addr=2, in=0xFFFF -> ready=0 next edge and mem[2] stays 0. ready returns 64 edges later. Writes during INIT are ignored.
- **Clear mid-sweep:** pulse clear at cnt=30 -> ready rises 64 edges after the clear edge, not 34.
- **Async reset mid-RUN and parameter sweep:** assert rst_n=0 between edges -> ready and registered out drop at once. Repeat the suite with WIDTH=8, ADDR_W=3 (ready after 8 edges) and WIDTH=32, ADDR_W=10.
